ball_motion_ctrl: RTL and testbench
===================================

Name: ball_motion_ctrl

Overview:
Frame-synchronous controller that sequences the bouncing-ball datapath of the VGA design. Once per frame, at the first cycle of vertical blanking, it computes the next ball position, direction, colour and bounce count, and commits them. Board switches are debounced here to pause, change speed or re-home the ball. It sits between the VGA timing counters (row/column) and the pixel draw logic.

Parameters:
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows
BALL_SIZE, 5, ball edge in pixels; XMAX = H_ACTIVE-BALL_SIZE, YMAX = V_ACTIVE-BALL_SIZE
X_INIT, 43, home x
Y_INIT, 71, home y
DEBOUNCE, 250000, cycles a switch level must be stable to be accepted

Ports:
i_Clk  in  1  pixel clock
i_Rst_L  in  1  asynchronous active-low reset
i_Row  in  10  current VGA row from timing counters
i_Column  in  10  current VGA column from timing counters
i_Switch_Pause  in  1  raw switch; each accepted press toggles pause
i_Switch_Speed  in  1  raw switch; debounced level high = step 2, low = step 1
i_Switch_Home  in  1  raw switch; accepted press requests re-home
o_Ball_X  out  10  committed ball x (top-left)
o_Ball_Y  out  10  committed ball y (top-left)
o_Color  out  9  committed RGB 3:3:3
o_Bounce_Count  out  8  wall hits, wraps mod 256
o_Paused  out  1  pause state
o_Busy  out  1  high while FSM not IDLE
o_Flash  out  1  see Optional Feature

Behaviour:
- Reset (async, i_Rst_L=0): X=X_INIT, Y=Y_INIT, dir_x=right, dir_y=down, Color=9'b111111000, Bounce_Count=0, Paused=0, Busy=0, Flash=0, FSM=IDLE, home request clear, debounce counters 0, debounced levels 0.
- Switch inputs: 2-FF synchroniser, then per-switch counter; debounced level updates only after DEBOUNCE consecutive cycles at the new value. A "press" is a debounced 0->1 transition.
- Pause press toggles Paused on the cycle after acceptance. Home press sets home_req; cleared at COMMIT.
- Frame tick: one-cycle pulse when i_Row==V_ACTIVE and i_Column==0. Ignored unless FSM=IDLE.
- FSM: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE, one cycle per state. Leave IDLE on tick if Paused=0 or home_req=1. Busy=1 in CALC_X/CALC_Y/COMMIT.
- Outputs change only at COMMIT (4 cycles after tick); stable across all active video.
- step = 2 if debounced speed level is high, else 1; sampled in CALC_X and held through CALC_Y.
- CALC_X, moving right: if X+step >= XMAX then nx=XMAX, dir_x=left, colour=9'b111000000, hit++; else nx=X+step. Moving left: if X <= step then nx=0, dir_x=right, colour=9'b000111000, hit++; else nx=X-step.
- CALC_Y, same rule against YMAX. Bottom hit colour 9'b000000111, top hit colour 9'b000111111. A Y-hit colour overrides an X-hit colour in the same frame.
- COMMIT: Bounce_Count += hits (0, 1 or 2, mod 256). If Color not hit this frame, keep it.
- If home_req: X=X_INIT, Y=Y_INIT, dir right/down, Color=9'b111111000, no count change. This overrides computed values and applies even when paused.
- Paused: position, colour and count frozen; debounce and home still active.
- Reset asserted mid-FSM: immediate return to reset values; no partial commit.

Optional Feature:
BOUNCE_FLASH_EN. When defined: any COMMIT with hits>0 loads a 3-bit frame counter with 7. o_Flash=1 while counter nonzero. Counter decrements on each frame tick, including while paused. A new hit reloads to 7. When undefined: o_Flash tied 0, no counter logic.

Test Plan:
1. Reset, DEBOUNCE=4, run 1 frame tick -> COMMIT 4 cycles later: X=44, Y=72, Color=111111000, Bounce_Count=0, Busy high exactly 3 cycles.
2. Force X=634, dir right, speed switch high -> next commit X=635, dir_x=left, Color=111000000, Bounce_Count=1; following frame X=633.
3. Corner: X=1, Y=1, dirs left/up, step 1 -> X=0, Y=0, Color=000111111 (Y overrides X), Bounce_Count +2.
4. Pause press held 4 cycles -> Paused=1; 3 ticks -> X/Y unchanged. Home press -> next tick X=43, Y=71, Color=111111000, Paused still 1.
5. Switch glitch of 3 cycles with DEBOUNCE=4 -> no toggle; hold for 4 cycles -> toggle. Reset pulse during CALC_Y -> outputs return to reset values, no commit.
6. With BOUNCE_FLASH_EN: hit commit -> o_Flash=1 for 7 subsequent ticks, then 0. Without the macro -> o_Flash always 0.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//   Frame-synchronous controller for the bouncing-ball datapath. On the first
//   cycle of vertical blanking it runs a short IDLE->CALC_X->CALC_Y->COMMIT
//   sequence that computes the next ball position, direction, colour and
//   bounce count, then commits them together so the draw logic sees stable
//   values for the whole active frame. Board switches are synchronised and
//   debounced here: pause (toggle), speed (level) and home (request).
//
// Optional feature macro: BOUNCE_FLASH_EN
//   Defined   : o_Flash stays high for 7 frame ticks after any wall hit.
//   Undefined : o_Flash is tied low and no flash counter exists.
//
// Ports:
//   i_Clk           pixel clock
//   i_Rst_L         asynchronous active-low reset
//   i_Row/i_Column  current VGA row/column from the timing counters
//   i_Switch_Pause  raw switch, each accepted press toggles pause
//   i_Switch_Speed  raw switch, debounced high = step 2, low = step 1
//   i_Switch_Home   raw switch, accepted press requests re-home
//   o_Ball_X/Y      committed ball top-left position
//   o_Color         committed RGB 3:3:3 colour
//   o_Bounce_Count  wall hits, wraps mod 256
//   o_Paused        pause state
//   o_Busy          high while the frame sequence is running
//   o_Flash         bounce flash indicator
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 5,
  parameter int X_INIT    = 43,
  parameter int Y_INIT    = 71,
  parameter int DEBOUNCE  = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [9:0] i_Row,
  input  logic [9:0] i_Column,
  input  logic       i_Switch_Pause,
  input  logic       i_Switch_Speed,
  input  logic       i_Switch_Home,
  output logic [9:0] o_Ball_X,
  output logic [9:0] o_Ball_Y,
  output logic [8:0] o_Color,
  output logic [7:0] o_Bounce_Count,
  output logic       o_Paused,
  output logic       o_Busy,
  output logic       o_Flash
);

  localparam logic [9:0] XMAX       = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] YMAX       = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] X_HOME     = 10'(X_INIT);
  localparam logic [9:0] Y_HOME     = 10'(Y_INIT);
  localparam logic [9:0] V_TICK_ROW = 10'(V_ACTIVE);

  localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  localparam logic [8:0] C_HOME   = 9'b111111000;
  localparam logic [8:0] C_RIGHT  = 9'b111000000;
  localparam logic [8:0] C_LEFT   = 9'b000111000;
  localparam logic [8:0] C_BOTTOM = 9'b000000111;
  localparam logic [8:0] C_TOP    = 9'b000111111;

  typedef enum logic [1:0] {S_IDLE, S_CALC_X, S_CALC_Y, S_COMMIT} state_t;

  // Advance one axis by step, clamping at the wall.
  // fwd=1 means increasing coordinate (right/down).
  // Result packs {hit, fwd_next, pos_next}.
  function automatic logic [11:0] wall_step(input logic [9:0] pos,
                                            input logic       fwd,
                                            input logic [1:0] step,
                                            input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + {9'b0, step};
    if (fwd) begin
      if (sum >= {1'b0, lim}) return {1'b1, 1'b0, lim};
      return {1'b0, 1'b1, sum[9:0]};
    end
    if (pos <= {8'b0, step}) return {1'b1, 1'b1, 10'd0};
    return {1'b0, 1'b0, pos - {8'b0, step}};
  endfunction

  // Switch index map: 0 pause, 1 speed, 2 home
  logic [2:0]            sw_meta, sw_sync, sw_level, sw_level_d, press;
  logic [2:0][CNT_W-1:0] db_cnt;

  state_t state, state_nxt;
  logic   paused, home_req, frame_tick;

  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y;
  logic [8:0] color;
  logic [7:0] bounce;

  logic [1:0]  step_now, step_p1;
  logic [11:0] x_res, y_res;
  logic [9:0]  x_p1, y_p2;
  logic        dir_x_p1, dir_y_p2, hit_x_p1, hit_y_p2;
  logic [8:0]  color_p1, color_p2;

  // ---- switch synchronise + debounce ----
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      sw_level   <= '0;
      sw_level_d <= '0;
      db_cnt     <= '0;
    end else begin
      sw_meta    <= {i_Switch_Home, i_Switch_Speed, i_Switch_Pause};
      sw_sync    <= sw_meta;
      sw_level_d <= sw_level;
      for (int i = 0; i < 3; i++) begin
        // Count consecutive cycles at the new value; any return resets it.
        if (sw_sync[i] == sw_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt[i]   <= '0;
          sw_level[i] <= sw_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = sw_level & ~sw_level_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      paused   <= 1'b0;
      home_req <= 1'b0;
    end else begin
      if (press[0]) paused <= ~paused;
      // A press landing on COMMIT wins so it is served next frame.
      if (press[2])                home_req <= 1'b1;
      else if (state == S_COMMIT)  home_req <= 1'b0;
    end
  end

  assign frame_tick = (i_Row == V_TICK_ROW) && (i_Column == 10'd0);

  // ---- frame sequencer ----
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_tick && (!paused || home_req)) state_nxt = S_CALC_X;
      S_CALC_X: state_nxt = S_CALC_Y;
      S_CALC_Y: state_nxt = S_COMMIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign o_Busy = (state != S_IDLE);

  assign step_now = sw_level[1] ? 2'd2 : 2'd1;
  assign x_res    = wall_step(ball_x, dir_x, step_now, XMAX);
  assign y_res    = wall_step(ball_y, dir_y, step_p1, YMAX);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ball_x   <= X_HOME;
      ball_y   <= Y_HOME;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      color    <= C_HOME;
      bounce   <= '0;
      step_p1  <= 2'd1;
      x_p1     <= X_HOME;
      dir_x_p1 <= 1'b1;
      hit_x_p1 <= 1'b0;
      color_p1 <= C_HOME;
      y_p2     <= Y_HOME;
      dir_y_p2 <= 1'b1;
      hit_y_p2 <= 1'b0;
      color_p2 <= C_HOME;
    end else begin
      case (state)
        // ---- stage p1: horizontal step, speed sampled here ----
        S_CALC_X: begin
          step_p1                        <= step_now;
          {hit_x_p1, dir_x_p1, x_p1}     <= x_res;
          color_p1 <= x_res[11] ? (dir_x ? C_RIGHT : C_LEFT) : color;
        end
        // ---- stage p2: vertical step; a Y hit colour overrides X ----
        S_CALC_Y: begin
          {hit_y_p2, dir_y_p2, y_p2}     <= y_res;
          color_p2 <= y_res[11] ? (dir_y ? C_BOTTOM : C_TOP) : color_p1;
        end
        // ---- commit: all outputs update together ----
        S_COMMIT: begin
          if (home_req) begin
            ball_x <= X_HOME;
            ball_y <= Y_HOME;
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
            color  <= C_HOME;
          end else begin
            ball_x <= x_p1;
            ball_y <= y_p2;
            dir_x  <= dir_x_p1;
            dir_y  <= dir_y_p2;
            color  <= color_p2;
            bounce <= bounce + {7'b0, hit_x_p1} + {7'b0, hit_y_p2};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BOUNCE_FLASH_EN
  logic [2:0] flash_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      flash_cnt <= '0;
    end else if (state == S_COMMIT && !home_req && (hit_x_p1 || hit_y_p2)) begin
      flash_cnt <= 3'd7;
    end else if (frame_tick && flash_cnt != 3'd0) begin
      flash_cnt <= flash_cnt - 3'd1;
    end
  end

  assign o_Flash = (flash_cnt != 3'd0);
`else
  assign o_Flash = 1'b0;
`endif

  assign o_Ball_X       = ball_x;
  assign o_Ball_Y       = ball_y;
  assign o_Color        = color;
  assign o_Bounce_Count = bounce;
  assign o_Paused       = paused;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_ctrl
//   Directed bench for ball_motion_ctrl using a small behavioural model and a
//   scoreboard queue of expected committed state, one entry per frame tick.
//   Small geometry: XMAX=35, YMAX=25, home (3,3), DEBOUNCE=4.
// ---------------------------------------------------------------------------
module tb_ball_motion_ctrl;

  localparam int H_ACT = 40;
  localparam int V_ACT = 30;
  localparam int BSZ   = 5;
  localparam int XI    = 3;
  localparam int YI    = 3;
  localparam int DEB   = 4;
  localparam int XMAX  = H_ACT - BSZ;
  localparam int YMAX  = V_ACT - BSZ;

  localparam logic [8:0] C_HOME   = 9'b111111000;
  localparam logic [8:0] C_RIGHT  = 9'b111000000;
  localparam logic [8:0] C_LEFT   = 9'b000111000;
  localparam logic [8:0] C_BOTTOM = 9'b000000111;
  localparam logic [8:0] C_TOP    = 9'b000111111;

  logic       clk, rst_n;
  logic [9:0] row, column;
  logic       sw_pause, sw_speed, sw_home;
  logic [9:0] ball_x, ball_y;
  logic [8:0] color;
  logic [7:0] bounce;
  logic       paused, busy, flash;

  ball_motion_ctrl #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .BALL_SIZE(BSZ),
    .X_INIT(XI), .Y_INIT(YI), .DEBOUNCE(DEB)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Row(row), .i_Column(column),
    .i_Switch_Pause(sw_pause), .i_Switch_Speed(sw_speed), .i_Switch_Home(sw_home),
    .o_Ball_X(ball_x), .o_Ball_Y(ball_y), .o_Color(color),
    .o_Bounce_Count(bounce), .o_Paused(paused), .o_Busy(busy), .o_Flash(flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [8:0] col;
    logic [7:0] cnt;
    logic       fl;
    logic       pz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // behavioural model state
  int         m_x, m_y, m_cnt, m_flash;
  bit         m_dx, m_dy, m_paused, m_home, m_speed;
  logic [8:0] m_col;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_x = XI; m_y = YI; m_dx = 1; m_dy = 1; m_col = C_HOME; m_cnt = 0;
    m_flash = 0; m_paused = 0; m_home = 0;
  endtask

  task automatic model_tick();
    int  stp, nx, ny;
    bit  hx, hy;
    if (m_flash > 0) m_flash--;
    if (m_paused && !m_home) return;
    if (m_home) begin
      m_x = XI; m_y = YI; m_dx = 1; m_dy = 1; m_col = C_HOME; m_home = 0;
      return;
    end
    stp = m_speed ? 2 : 1;
    hx = 0; hy = 0;
    if (m_dx) begin
      nx = m_x + stp;
      if (nx >= XMAX) begin nx = XMAX; m_dx = 0; m_col = C_RIGHT; hx = 1; end
    end else begin
      nx = m_x - stp;
      if (nx <= 0) begin nx = 0; m_dx = 1; m_col = C_LEFT; hx = 1; end
    end
    if (m_dy) begin
      ny = m_y + stp;
      if (ny >= YMAX) begin ny = YMAX; m_dy = 0; m_col = C_BOTTOM; hy = 1; end
    end else begin
      ny = m_y - stp;
      if (ny <= 0) begin ny = 0; m_dy = 1; m_col = C_TOP; hy = 1; end
    end
    m_x = nx; m_y = ny;
    m_cnt = (m_cnt + int'(hx) + int'(hy)) % 256;
`ifdef BOUNCE_FLASH_EN
    if (hx || hy) m_flash = 7;
`endif
  endtask

  // One frame tick: push expectation, pulse tick, count busy, compare.
  task automatic frame();
    exp_t e;
    bit   run;
    int   busy_cycles;
    run = !m_paused || m_home;
    model_tick();
    e.x = 10'(m_x); e.y = 10'(m_y); e.col = m_col; e.cnt = 8'(m_cnt);
    e.fl = (m_flash != 0); e.pz = m_paused;
    sb.push_back(e);
    @(negedge clk); row = 10'(V_ACT); column = 10'd0;
    @(negedge clk); row = 10'd0;      column = 10'd1;
    busy_cycles = 0;
    while (busy && busy_cycles < 8) begin
      busy_cycles++;
      @(negedge clk);
    end
    chk("busy_cycles", busy_cycles, run ? 3 : 0);
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    chk("ball_x", ball_x, e.x);
    chk("ball_y", ball_y, e.y);
    chk("color",  color,  e.col);
    chk("bounce", bounce, e.cnt);
    chk("flash",  flash,  e.fl);
    chk("paused", paused, e.pz);
  endtask

  task automatic hold_switch(input int which, input int cycles);
    @(negedge clk);
    if (which == 0) sw_pause = 1'b1;
    else            sw_home  = 1'b1;
    repeat (cycles) @(negedge clk);
    sw_pause = 1'b0;
    sw_home  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_x"},      ball_x, XI);
    chk({pfx, "_y"},      ball_y, YI);
    chk({pfx, "_color"},  color,  C_HOME);
    chk({pfx, "_bounce"}, bounce, 0);
    chk({pfx, "_paused"}, paused, 0);
    chk({pfx, "_busy"},   busy,   0);
    chk({pfx, "_flash"},  flash,  0);
  endtask

  initial begin
    rst_n = 1'b0; row = 10'd0; column = 10'd1;
    sw_pause = 1'b0; sw_speed = 1'b0; sw_home = 1'b0;
    m_speed = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // first frame: step 1 right/down from home
    frame();
    chk("first_x", ball_x, XI + 1);
    chk("first_y", ball_y, YI + 1);

    // run to frame 347: both axes reach the top-left corner together
    for (int f = 2; f <= 347; f++) frame();
    chk("corner_x",      ball_x, 0);
    chk("corner_y",      ball_y, 0);
    chk("corner_color",  color,  C_TOP);
    chk("corner_bounce", bounce, 24);

    // speed high: step 2, right wall clamp at frame 18
    sw_speed = 1'b1; m_speed = 1;
    repeat (12) @(negedge clk);
    for (int f = 1; f <= 18; f++) frame();
    chk("rwall_x",      ball_x, XMAX);
    chk("rwall_color",  color,  C_RIGHT);
    chk("rwall_bounce", bounce, 26);
    frame();
    chk("after_rwall_x", ball_x, XMAX - 2);

    // pause: three ticks leave everything frozen
    hold_switch(0, 10); m_paused = 1;
    chk("pause_on", paused, 1);
    for (int f = 0; f < 3; f++) frame();

    // home while paused
    hold_switch(2, 10); m_home = 1;
    frame();
    chk("home_x",      ball_x, XI);
    chk("home_color",  color,  C_HOME);
    chk("home_paused", paused, 1);
    frame();

    // 3-cycle glitch is rejected, 4-cycle hold is accepted
    hold_switch(0, 3);
    chk("glitch_paused", paused, 1);
    hold_switch(0, 4); m_paused = 0;
    chk("hold4_paused", paused, 0);

    // run through a wall hit and the following flash window
    for (int f = 0; f < 22; f++) frame();

    // reset pulse during CALC_Y: no partial commit
    sw_speed = 1'b0; m_speed = 0;
    repeat (12) @(negedge clk);
    @(negedge clk); row = 10'(V_ACT); column = 10'd0;
    @(negedge clk); row = 10'd0;      column = 10'd1;
    @(negedge clk);
    chk("midfsm_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_reset_vals("postrst");
    model_reset();
    frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
